// File: rtl/lifo_stack_arbiter.sv
// Two-requester round-robin arbiter serialising push/pop/peek onto a private LIFO stack.
// Optional owner tagging of entries is enabled by defining LIFO_ARB_OWNER_TAG_EN.
module lifo_stack_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              Clk_In,
  input  logic              Reset_In,
  input  logic              Req_A_In,
  input  logic              Req_B_In,
  input  logic [1:0]        Op_A_In,
  input  logic [1:0]        Op_B_In,
  input  logic [DATA_W-1:0] Data_A_In,
  input  logic [DATA_W-1:0] Data_B_In,
  output logic              Gnt_A_Out,
  output logic              Gnt_B_Out,
  output logic              Ack_A_Out,
  output logic              Ack_B_Out,
  output logic [DATA_W-1:0] Rd_Data_Out,
  output logic              Err_Out,
  output logic [CNT_W-1:0]  Count_Out,
  output logic              Empty_Out,
  output logic              Full_Out,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester holds Req (with stable Op/Data) until its one-cycle
  // Ack pulse and drops it the cycle after; Gnt pulses once on acceptance.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              last_b;
  logic              win_b;
  logic [1:0]        lat_op;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              do_push;
  logic              do_pop;
  logic              pick_b;
  logic              tag_bad;
  logic [AW-1:0]     push_idx;
  logic [AW-1:0]     top_idx;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef LIFO_ARB_OWNER_TAG_EN
  logic              tag_mem [DEPTH];
`endif

  assign push_idx  = count[AW-1:0];
  assign top_idx   = AW'(count - 1'b1);
  assign Count_Out = count;
  assign Empty_Out = (count == '0);
  assign Full_Out  = (count == CNT_W'(DEPTH));
  assign fsm_state = state;

  // On a tie the requester not granted last wins.
  always_comb begin
    pick_b = Req_B_In && (!Req_A_In || !last_b);
  end

  always_comb begin
`ifdef LIFO_ARB_OWNER_TAG_EN
    tag_bad = (tag_mem[top_idx] != win_b);
`else
    tag_bad = 1'b0;
`endif
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state       <= IDLE;
      count       <= '0;
      last_b      <= 1'b1;
      win_b       <= 1'b0;
      lat_op      <= 2'b00;
      lat_data    <= '0;
      res_data    <= '0;
      res_err     <= 1'b0;
      do_push     <= 1'b0;
      do_pop      <= 1'b0;
      Gnt_A_Out   <= 1'b0;
      Gnt_B_Out   <= 1'b0;
      Ack_A_Out   <= 1'b0;
      Ack_B_Out   <= 1'b0;
      Rd_Data_Out <= '0;
      Err_Out     <= 1'b0;
    end else begin
      Gnt_A_Out   <= 1'b0;
      Gnt_B_Out   <= 1'b0;
      Ack_A_Out   <= 1'b0;
      Ack_B_Out   <= 1'b0;
      Rd_Data_Out <= '0;
      Err_Out     <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_A_In || Req_B_In) begin
            win_b     <= pick_b;
            last_b    <= pick_b;
            lat_op    <= pick_b ? Op_B_In : Op_A_In;
            lat_data  <= pick_b ? Data_B_In : Data_A_In;
            Gnt_A_Out <= !pick_b;
            Gnt_B_Out <= pick_b;
            state     <= EXEC;
          end
        end
        EXEC: begin
          res_data <= '0;
          res_err  <= 1'b0;
          do_push  <= 1'b0;
          do_pop   <= 1'b0;
          case (lat_op)
            OP_PUSH: begin
              if (count < CNT_W'(DEPTH)) do_push <= 1'b1;
              else                       res_err <= 1'b1;
            end
            OP_POP, OP_PEEK: begin
              if ((count != '0) && !tag_bad) begin
                res_data <= mem[top_idx];
                do_pop   <= (lat_op == OP_POP);
              end else begin
                res_err  <= 1'b1;
              end
            end
            default: res_err <= 1'b1;
          endcase
          state <= RESP;
        end
        RESP: begin
          // Stack occupancy commits together with the Ack pulse.
          if (do_push)     count <= count + 1'b1;
          else if (do_pop) count <= count - 1'b1;
          do_push     <= 1'b0;
          do_pop      <= 1'b0;
          Ack_A_Out   <= !win_b;
          Ack_B_Out   <= win_b;
          Rd_Data_Out <= res_data;
          Err_Out     <= res_err;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge Clk_In) begin
    if ((state == RESP) && do_push) begin
      mem[push_idx] <= lat_data;
`ifdef LIFO_ARB_OWNER_TAG_EN
      tag_mem[push_idx] <= win_b;
`endif
    end
  end

endmodule

// File: tb/tb_lifo_stack_arbiter.sv
// Directed bench for lifo_stack_arbiter: timing, arbitration, saturation, reset, owner tags.
module tb_lifo_stack_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, ack_a, ack_b;
  logic [7:0] rd_data;
  logic       err;
  logic [3:0] count;
  logic       empty, full;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  lifo_stack_arbiter #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .Clk_In(clk), .Reset_In(rst),
    .Req_A_In(req_a), .Req_B_In(req_b),
    .Op_A_In(op_a), .Op_B_In(op_b),
    .Data_A_In(data_a), .Data_B_In(data_b),
    .Gnt_A_Out(gnt_a), .Gnt_B_Out(gnt_b),
    .Ack_A_Out(ack_a), .Ack_B_Out(ack_b),
    .Rd_Data_Out(rd_data), .Err_Out(err),
    .Count_Out(count), .Empty_Out(empty), .Full_Out(full),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full",  32'(full),  32'(0));
    chk("rst_gnt",   32'({gnt_a, gnt_b}), 32'(0));
    chk("rst_ack",   32'({ack_a, ack_b}), 32'(0));
    chk("rst_rd",    32'({err, rd_data}), 32'(0));
    chk("rst_state", 32'(fsm_state), 32'(0));
  endtask

  // Single transaction from one requester; called just after a rising edge.
  task automatic run_op(input logic is_b, input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err, input logic [3:0] exp_cnt);
    if (is_b) begin req_b = 1'b1; op_b = op; data_b = d; end
    else      begin req_a = 1'b1; op_a = op; data_a = d; end
    @(posedge clk); #1;
    chk("gnt", 32'({gnt_a, gnt_b}), 32'(is_b ? 2'b01 : 2'b10));
    @(posedge clk); #1;
    chk("gnt_pulse", 32'({gnt_a, gnt_b, ack_a, ack_b}), 32'(0));
    @(posedge clk); #1;
    chk("ack",   32'({ack_a, ack_b}), 32'(is_b ? 2'b01 : 2'b10));
    chk("rd",    32'(rd_data), 32'(exp_rd));
    chk("err",   32'(err), 32'(exp_err));
    chk("count", 32'(count), 32'(exp_cnt));
    if (is_b) req_b = 1'b0; else req_a = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'({ack_a, ack_b, err, rd_data}), 32'(0));
  endtask

  initial begin
    rst = 1'b1; req_a = 0; req_b = 0; op_a = 0; op_b = 0; data_a = 0; data_b = 0;

    // basic push
    do_reset();
    run_op(1'b0, 2'b00, 8'h11, 8'h00, 1'b0, 4'd1);
    chk("empty_after_push", 32'(empty), 32'(0));

    // pop and peek
    do_reset();
    run_op(1'b0, 2'b00, 8'hA1, 8'h00, 1'b0, 4'd1);
    run_op(1'b1, 2'b00, 8'hB2, 8'h00, 1'b0, 4'd2);
    run_op(1'b1, 2'b01, 8'h00, 8'hB2, 1'b0, 4'd1);
    run_op(1'b0, 2'b10, 8'h00, 8'hA1, 1'b0, 4'd1);

    // tie alternation A, B, A, B
    do_reset();
    op_a = 2'b00; op_b = 2'b00; data_a = 8'h61; data_b = 8'h62;
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("tie_gnt", 32'({gnt_a, gnt_b}), 32'((i % 2) ? 2'b01 : 2'b10));
      if (i == 1) begin req_a = 1'b1; data_a = 8'h63; end
      if (i == 2) begin req_b = 1'b1; data_b = 8'h64; end
      @(posedge clk);
      @(posedge clk); #1;
      chk("tie_ack", 32'({ack_a, ack_b}), 32'((i % 2) ? 2'b01 : 2'b10));
      if (i % 2) req_b = 1'b0; else req_a = 1'b0;
    end
    @(posedge clk); #1;
    chk("tie_count", 32'(count), 32'(4));
    run_op(1'b0, 2'b01, 8'h00, 8'h64, 1'b0, 4'd3);
    run_op(1'b0, 2'b01, 8'h00, 8'h63, 1'b0, 4'd2);

    // fill, overflow, drain, underflow, reserved op
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_op(i[0], 2'b00, 8'h80 + 8'(i * 3), 8'h00, 1'b0, 4'(i + 1));
      exp_q.push_back(8'h80 + 8'(i * 3));
    end
    chk("full", 32'(full), 32'(1));
    run_op(1'b0, 2'b00, 8'hEE, 8'h00, 1'b1, 4'd8);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = exp_q.pop_back();
      run_op(1'b0, 2'b01, 8'h00, e, 1'b0, 4'(7 - i));
    end
    chk("empty", 32'(empty), 32'(1));
    run_op(1'b1, 2'b01, 8'h00, 8'h00, 1'b1, 4'd0);
    run_op(1'b1, 2'b10, 8'h00, 8'h00, 1'b1, 4'd0);
    run_op(1'b0, 2'b11, 8'h33, 8'h00, 1'b1, 4'd0);

    // reset in EXEC abandons the transaction, tie then goes to A
    run_op(1'b1, 2'b00, 8'h44, 8'h00, 1'b0, 4'd1);
    req_a = 1'b1; op_a = 2'b00; data_a = 8'h55;
    @(posedge clk); #1;
    chk("mid_gnt", 32'({gnt_a, gnt_b}), 32'(2'b10));
    #2 rst = 1'b1;
    req_a = 1'b0;
    #4 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_no_ack", 32'({ack_a, ack_b}), 32'(0));
    end
    chk("mid_count", 32'(count), 32'(0));
    chk("mid_state", 32'(fsm_state), 32'(0));
    req_a = 1'b1; req_b = 1'b1; op_a = 2'b00; op_b = 2'b00; data_a = 8'h71; data_b = 8'h72;
    @(posedge clk); #1;
    chk("post_rst_tie", 32'({gnt_a, gnt_b}), 32'(2'b10));
    do_reset();

    // owner tags
    run_op(1'b0, 2'b00, 8'h5A, 8'h00, 1'b0, 4'd1);
`ifdef LIFO_ARB_OWNER_TAG_EN
    run_op(1'b1, 2'b01, 8'h00, 8'h00, 1'b1, 4'd1);
    run_op(1'b0, 2'b01, 8'h00, 8'h5A, 1'b0, 4'd0);
`else
    run_op(1'b1, 2'b10, 8'h00, 8'h5A, 1'b0, 4'd1);
    run_op(1'b1, 2'b01, 8'h00, 8'h5A, 1'b0, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lifo_stack_arbiter.md
# lifo_stack_arbiter

Two-requester arbiter and sequencer wrapped around a private 8x8 LIFO stack. Requesters A and B issue push/pop/peek over a Req/Gnt/Ack handshake. A round-robin arbiter serialises their operations onto the single stack and returns read data and error status. The block is the shared stack resource for two independent client blocks in the data-storage group.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 8, number of stack entries
- CNT_W, 4, occupancy counter width; must hold DEPTH, i.e. clog2(DEPTH)+1
- Clk_In  in  1  clock; all state updates on the rising edge
- Reset_In  in  1  reset, asynchronous, active-high
- Req_A_In / Req_B_In  in  1  request from A / B; held high until the matching Ack
- Op_A_In / Op_B_In  in  2  operation: 00 push, 01 pop, 10 peek, 11 reserved
- Data_A_In / Data_B_In  in  DATA_W  push data; stable while Req is high
- Gnt_A_Out / Gnt_B_Out  out  1  one-cycle pulse: request accepted
- Ack_A_Out / Ack_B_Out  out  1  one-cycle pulse: operation complete
- Rd_Data_Out  out  DATA_W  pop/peek result; valid only while an Ack is high
- Err_Out  out  1  operation rejected; valid only while an Ack is high
- Count_Out  out  CNT_W  current occupancy, 0..DEPTH
- Empty_Out / Full_Out  out  1  Count==0 / Count==DEPTH (combinational from Count)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no Req is high, stay in IDLE.
  - Otherwise arbitrate, latch the winner's Op and Data, assert that requester's Gnt for one cycle, and go to EXEC.
- Arbitration:
  - If only one Req is high, that requester wins.
  - If both are high, the winner is the requester not granted last. Last_Grant updates on every grant.
- EXEC: perform the operation, register the result, go to RESP.
  - Push when Count<DEPTH: mem[Count] <= Data, Count+1, Rd_Data=0, Err=0.
  - Pop when Count>0: Rd_Data=mem[Count-1], Count-1.
  - Peek when Count>0: Rd_Data=mem[Count-1], Count unchanged.
  - Push when full, pop/peek when empty, or Op=11: Err=1, Rd_Data=0, stack unchanged.
- RESP: assert the winner's Ack for one cycle with Rd_Data and Err, then return to IDLE.
- The requester must drop Req in the cycle after it sees Ack. A Req still high in IDLE is treated as a new request.
- Outside an Ack cycle, Rd_Data_Out and Err_Out are 0. Outputs are never high-impedance.
- Count never wraps; saturation is enforced by the error rules above.
- Reset (any state, including mid-transaction):
  - FSM returns to IDLE; Count=0; Last_Grant=B, so A wins the first tie.
  - All Gnt, Ack, Rd_Data and Err outputs are 0; Empty=1, Full=0.
  - Memory contents are not cleared.
  - A transaction in flight is abandoned with no Ack.

## Timing
- Req is sampled high at edge k in IDLE.
  - Gnt is high for cycle k..k+1.
  - Stack update occurs at edge k+2.
  - Ack, Rd_Data and Err are high/valid for cycle k+2..k+3.
- Count_Out reflects a push or pop from edge k+2, coincident with Ack.
- Throughput: one operation per 3 cycles. Back-to-back alternation of A and B is possible from the IDLE following each RESP.
- The losing requester keeps Req high and is granted in the next IDLE, so worst-case wait is one transaction.

## Configuration
- LIFO_ARB_OWNER_TAG_EN defined:
  - Each entry stores a 1-bit owner tag (A=0, B=1) with its data.
  - A pop or peek whose requester does not own the top entry returns Err=1, Rd_Data=0, and leaves the stack unchanged.
  - Push is unaffected.
- Undefined:
  - No tag storage.
  - Either requester may pop or peek any entry.

## Test plan
- Reset, then A pushes 8'h11 → Gnt_A one cycle after Req, Ack_A two cycles later, Err=0, Count=1, Empty=0.
- A pushes 8'hA1, B pushes 8'hB2, then B pops → Ack_B with Rd_Data=8'hB2, Count=1. A peek then returns 8'hA1 with Count unchanged.
- Both Req high from reset, each pushing → order of grants is A, B, A, B. Neither requester is granted twice in a row.
- Push 8 entries and attempt a 9th → Err=1, Full=1, Count=8. Pop 8 times → data returned in reverse push order. A 9th pop → Err=1, Rd_Data=0. Op=11 → Err=1.
- Assert Reset_In during EXEC of a push → no Ack, Count=0, FSM in IDLE. A subsequent tie is granted to A.
- With LIFO_ARB_OWNER_TAG_EN defined: A pushes 8'h5A, B pops → Err=1, Count=1. A pops → Rd_Data=8'h5A, Err=0.
